// File: rtl/spi_byte_phy.sv
// SPI mode-0 slave front-end: synchronises the SPI pins into SysClk, deserialises MOSI
// into bytes and serialises txByte onto MISO, MSB first, with per-frame framing pulses.
module spi_byte_phy #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       SysClk,
  input  logic       Reset_n,
  input  logic       SPI_CLK,
  input  logic       SPI_SS,
  input  logic       SPI_MOSI,
  output logic       SPI_MISO,
  output logic [7:0] rcByte,
  output logic       rcByteValid,
  input  logic [7:0] txByte,
  output logic       txByteLoad,
  output logic       frameStart,
  output logic       frameEnd,
  output logic       partialByte
);

  localparam int FLUSH_W = $clog2(SYNC_STAGES + 2);
  localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(SYNC_STAGES + 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0]   ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0]   mosi_sync_q, mosi_sync_d;
  logic                     clk_dly_q, clk_dly_d;
  logic                     ss_dly_q, ss_dly_d;
  logic [FLUSH_W-1:0]       flush_cnt_q, flush_cnt_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [7:0]               rx_shift_q, rx_shift_d;
  logic [7:0]               tx_shift_q, tx_shift_d;
  logic [7:0]               rc_byte_q, rc_byte_d;
  logic                     rc_valid_q, rc_valid_d;
  logic                     tx_load_q, tx_load_d;
  logic                     frame_start_q, frame_start_d;
  logic                     frame_end_q, frame_end_d;
  logic                     partial_q, partial_d;
  logic                     miso_q, miso_d;
  logic                     rise_seen_q, rise_seen_d;

  logic clk_s, ss_s, mosi_s;
  logic clk_rise, clk_fall, ss_fall, ss_rise, settled;

  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_dly_q;
  assign clk_fall = ~clk_s & clk_dly_q;
  assign ss_fall  = ~ss_s & ss_dly_q;
  assign ss_rise  = ss_s & ~ss_dly_q;
  // After reset the chains hold idle levels; edges are only trusted once real pin values reach the end.
  assign settled  = (flush_cnt_q == FLUSH_DONE);

  // Synchroniser shift and edge-detect delay taps.
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], SPI_CLK};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SPI_SS};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
    clk_dly_d   = clk_s;
    ss_dly_d    = ss_s;
  end

  // Frame FSM, shift registers and registered output pulses.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    rc_byte_d     = rc_byte_q;
    rise_seen_d   = rise_seen_q;
    rc_valid_d    = 1'b0;
    tx_load_d     = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    partial_d     = 1'b0;
    if (settled) begin
      flush_cnt_d = flush_cnt_q;
    end else begin
      flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (ss_fall && settled) begin
          state_d       = ST_ACTIVE;
          frame_start_d = 1'b1;
          tx_shift_d    = txByte;
          tx_load_d     = 1'b1;
          bit_cnt_d     = 3'd0;
          rx_shift_d    = 8'h00;
          rise_seen_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (ss_rise) begin
          state_d     = ST_IDLE;
          frame_end_d = 1'b1;
          partial_d   = (bit_cnt_q != 3'd0);
          bit_cnt_d   = 3'd0;
        end else if (clk_rise) begin
          rx_shift_d  = {rx_shift_q[6:0], mosi_s};
          bit_cnt_d   = bit_cnt_q + 3'd1;
          rise_seen_d = 1'b1;
          if (bit_cnt_q == 3'd7) begin
            rc_byte_d  = {rx_shift_q[6:0], mosi_s};
            rc_valid_d = 1'b1;
          end else begin
            rc_valid_d = 1'b0;
          end
        end else if (clk_fall) begin
          // A fall at bitCnt 0 is a byte boundary only once a rise has happened this frame.
          if ((bit_cnt_q == 3'd0) && rise_seen_q) begin
            tx_shift_d = txByte;
            tx_load_d  = 1'b1;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d == ST_ACTIVE) begin
      miso_d = tx_shift_d[7];
    end else begin
      miso_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge SysClk) begin
    if (!Reset_n) begin
      state_q       <= ST_IDLE;
      clk_sync_q    <= {SYNC_STAGES{1'b0}};
      ss_sync_q     <= {SYNC_STAGES{1'b1}};
      mosi_sync_q   <= {SYNC_STAGES{1'b0}};
      clk_dly_q     <= 1'b0;
      ss_dly_q      <= 1'b1;
      flush_cnt_q   <= {FLUSH_W{1'b0}};
      bit_cnt_q     <= 3'd0;
      rx_shift_q    <= 8'h00;
      tx_shift_q    <= 8'h00;
      rc_byte_q     <= 8'h00;
      rc_valid_q    <= 1'b0;
      tx_load_q     <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      partial_q     <= 1'b0;
      miso_q        <= 1'b0;
      rise_seen_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      clk_sync_q    <= clk_sync_d;
      ss_sync_q     <= ss_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      clk_dly_q     <= clk_dly_d;
      ss_dly_q      <= ss_dly_d;
      flush_cnt_q   <= flush_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      rc_byte_q     <= rc_byte_d;
      rc_valid_q    <= rc_valid_d;
      tx_load_q     <= tx_load_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      partial_q     <= partial_d;
      miso_q        <= miso_d;
      rise_seen_q   <= rise_seen_d;
    end
  end

  assign SPI_MISO    = miso_q;
  assign rcByte      = rc_byte_q;
  assign rcByteValid = rc_valid_q;
  assign txByteLoad  = tx_load_q;
  assign frameStart  = frame_start_q;
  assign frameEnd    = frame_end_q;
  assign partialByte = partial_q;

endmodule

// File: tb/tb_spi_byte_phy.sv
// Directed bench for spi_byte_phy: drives SPI frames at 16x oversampling and checks
// received bytes, MISO bit streams, framing pulses and pulse latency.
module tb_spi_byte_phy;

  logic       SysClk;
  logic       Reset_n;
  logic       SPI_CLK;
  logic       SPI_SS;
  logic       SPI_MOSI;
  logic       SPI_MISO;
  logic [7:0] rcByte;
  logic       rcByteValid;
  logic [7:0] txByte;
  logic       txByteLoad;
  logic       frameStart;
  logic       frameEnd;
  logic       partialByte;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int valid_cyc = 0;
  int valid_cnt = 0;
  int load_cnt = 0;
  int fs_cnt = 0;
  int fe_cnt = 0;
  int pb_cnt = 0;
  int overlap_cnt = 0;
  logic [7:0] rx_q[$];

  spi_byte_phy #(.SYNC_STAGES(2)) dut (
    .SysClk      (SysClk),
    .Reset_n     (Reset_n),
    .SPI_CLK     (SPI_CLK),
    .SPI_SS      (SPI_SS),
    .SPI_MOSI    (SPI_MOSI),
    .SPI_MISO    (SPI_MISO),
    .rcByte      (rcByte),
    .rcByteValid (rcByteValid),
    .txByte      (txByte),
    .txByteLoad  (txByteLoad),
    .frameStart  (frameStart),
    .frameEnd    (frameEnd),
    .partialByte (partialByte)
  );

  initial SysClk = 1'b0;
  always #5 SysClk = ~SysClk;

  // Pulse monitor: counts each output pulse, sampled 1 ns after the active edge.
  always begin
    @(posedge SysClk);
    cyc = cyc + 1;
    #1;
    if (rcByteValid) begin
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
      rx_q.push_back(rcByte);
    end
    if (txByteLoad)  load_cnt = load_cnt + 1;
    if (frameStart)  fs_cnt = fs_cnt + 1;
    if (frameEnd)    fe_cnt = fe_cnt + 1;
    if (partialByte) pb_cnt = pb_cnt + 1;
    if (rcByteValid && txByteLoad) overlap_cnt = overlap_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge SysClk);
  endtask

  // One SPI bit per iteration, MSB first; MISO sampled just before each rising SPI_CLK.
  task automatic send_bits(input logic [7:0] val, input int n, output logic [7:0] miso_bits);
    miso_bits = 8'h00;
    for (int i = 0; i < n; i++) begin
      SPI_MOSI = val[7-i];
      wait_cyc(4);
      miso_bits = {miso_bits[6:0], SPI_MISO};
      SPI_CLK = 1'b1;
      rise_cyc = cyc;
      wait_cyc(8);
      SPI_CLK = 1'b0;
      wait_cyc(4);
    end
  endtask

  initial begin
    logic [7:0] mb;
    int v0;
    int f0;
    int e0;
    Reset_n  = 1'b0;
    SPI_CLK  = 1'b0;
    SPI_SS   = 1'b1;
    SPI_MOSI = 1'b0;
    txByte   = 8'h00;

    // Reset held for three cycles.
    wait_cyc(3);
    check("rst_miso",    {31'd0, SPI_MISO},    32'd0);
    check("rst_rcbyte",  {24'd0, rcByte},      32'd0);
    check("rst_pulses",  {27'd0, rcByteValid, txByteLoad, frameStart, frameEnd, partialByte}, 32'd0);
    Reset_n = 1'b1;
    wait_cyc(10);
    check("idle_no_frame", fs_cnt, 0);

    // Frame 1: receive A5 then 5A, transmit 3C then C3.
    txByte = 8'h3C;
    SPI_SS = 1'b0;
    wait_cyc(8);
    check("f1_frame_start", fs_cnt, 1);
    check("f1_load_on_ss",  load_cnt, 1);
    check("f1_miso_first",  {31'd0, SPI_MISO}, 32'd0);
    txByte = 8'hC3;
    send_bits(8'hA5, 8, mb);
    check("f1_rcbyte_a5",  {24'd0, rcByte}, 32'h0000_00A5);
    check("f1_valid_once", valid_cnt, 1);
    check("f1_latency",    valid_cyc - rise_cyc, 3);
    check("f1_miso_3c",    {24'd0, mb}, 32'h0000_003C);
    check("f1_load_byte1", load_cnt, 2);
    send_bits(8'h5A, 8, mb);
    check("f1_rcbyte_5a",  {24'd0, rcByte}, 32'h0000_005A);
    check("f1_miso_c3",    {24'd0, mb}, 32'h0000_00C3);
    SPI_SS = 1'b1;
    wait_cyc(8);
    check("f1_frame_end",  fe_cnt, 1);
    check("f1_no_partial", pb_cnt, 0);
    check("f1_miso_idle",  {31'd0, SPI_MISO}, 32'd0);

    // Frame 2: three bytes in order.
    rx_q.delete();
    SPI_SS = 1'b0;
    wait_cyc(8);
    send_bits(8'h03, 8, mb);
    send_bits(8'h12, 8, mb);
    send_bits(8'h34, 8, mb);
    SPI_SS = 1'b1;
    wait_cyc(8);
    check("f2_count", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      check("f2_byte0", {24'd0, rx_q[0]}, 32'h0000_0003);
      check("f2_byte1", {24'd0, rx_q[1]}, 32'h0000_0012);
      check("f2_byte2", {24'd0, rx_q[2]}, 32'h0000_0034);
    end else begin
      check("f2_bytes_present", rx_q.size(), 3);
    end
    check("f2_frame_end",  fe_cnt, 2);
    check("f2_no_partial", pb_cnt, 0);

    // Frame 3: aborted after five bits, then a clean byte in the next frame.
    v0 = valid_cnt;
    SPI_SS = 1'b0;
    wait_cyc(8);
    send_bits(8'hB0, 5, mb);
    SPI_SS = 1'b1;
    wait_cyc(8);
    check("f3_frame_end", fe_cnt, 3);
    check("f3_partial",   pb_cnt, 1);
    check("f3_no_valid",  valid_cnt, v0);
    check("f3_rcbyte_held", {24'd0, rcByte}, 32'h0000_0034);
    SPI_SS = 1'b0;
    wait_cyc(8);
    send_bits(8'h96, 8, mb);
    SPI_SS = 1'b1;
    wait_cyc(8);
    check("f4_rcbyte_96", {24'd0, rcByte}, 32'h0000_0096);
    check("f4_valid_one", valid_cnt, v0 + 1);
    check("f4_no_partial", pb_cnt, 1);

    // Reset in the middle of a byte, then a fresh frame.
    SPI_SS = 1'b0;
    wait_cyc(8);
    send_bits(8'hE0, 3, mb);
    Reset_n = 1'b0;
    wait_cyc(3);
    Reset_n = 1'b1;
    v0 = valid_cnt;
    f0 = fs_cnt;
    e0 = fe_cnt;
    wait_cyc(12);
    check("r_no_stale_start", fs_cnt, f0);
    check("r_miso_zero", {31'd0, SPI_MISO}, 32'd0);
    SPI_SS = 1'b1;
    wait_cyc(8);
    check("r_no_frame_end", fe_cnt, e0);
    SPI_SS = 1'b0;
    wait_cyc(8);
    check("r_frame_start", fs_cnt, f0 + 1);
    send_bits(8'hFF, 8, mb);
    SPI_SS = 1'b1;
    wait_cyc(8);
    check("r_rcbyte_ff",  {24'd0, rcByte}, 32'h0000_00FF);
    check("r_valid_one",  valid_cnt, v0 + 1);
    check("no_overlap",   overlap_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
